// File: rtl/bb_lcd_pkg.sv
// Shared constants and helpers for the N-digit BCD counter with static LCD drive.
// The segment bit order is a..g = bit 0..6.
package bb_lcd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_E     = 7'b0111001;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;

    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_E;
        endcase
    endfunction

    // Returns {carry, digit}; any value >= 9 (including illegal codes) rolls to 0.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d);
        if (d >= 4'd9) return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    // Returns {borrow, digit}; an illegal code clamps to 9 without borrowing.
    function automatic logic [4:0] bcd_dec(input logic [3:0] d);
        if (d == 4'd0) return {1'b1, 4'd9};
        if (d > 4'd9)  return {1'b0, 4'd9};
        return {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/bb_bcd_digit_updn.sv
// One BCD digit of the up/down chain: steps when tick and carry/borrow-in are both set.
module bb_bcd_digit_updn
    import bb_lcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [3:0] load_dig_i,
    input  logic       cin_i,
    output logic [3:0] dig_o,
    output logic       cout_o
);

    logic [3:0] dig_q, dig_d;
    logic [4:0] inc_r, dec_r;

    always_comb begin
        inc_r  = bcd_inc(dig_q);
        dec_r  = bcd_dec(dig_q);
        dig_d  = dig_q;
        cout_o = 1'b0;
        if (load_i) begin
            dig_d = load_dig_i;
        end else if (tick_i && cin_i) begin
            if (up_i) {cout_o, dig_d} = inc_r;
            else      {cout_o, dig_d} = dec_r;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) dig_q <= 4'd0;
        else       dig_q <= dig_d;
    end

    assign dig_o = dig_q;

endmodule

// File: rtl/bb_lcd_ncnt.sv
// N-digit BCD up/down counter driving a static (AC) 7-segment LCD.
// Count and frame rates are derived from the slow clock by two prescalers.
module bb_lcd_ncnt
    import bb_lcd_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned CNT_DIV   = 2048,
    parameter int unsigned FRAME_DIV = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  blank_lz_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  step_o,
    output logic                  wrap_o,
    output logic                  lcdcom_o,
    output logic [7*DIGITS-1:0]   lcdseg_o
);

    localparam int unsigned CNT_W = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int unsigned FRM_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(CNT_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0]  pre_q, pre_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              com_q, com_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              tick;
    logic              frm_wrap;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] blank;
    logic              lead;

    assign tick     = en_i && (pre_q == PRE_MAX);
    assign frm_wrap = (frm_q == FRM_MAX);

    always_comb begin
        pre_d = pre_q;
        if (load_i)     pre_d = '0;
        else if (en_i)  pre_d = tick ? '0 : pre_q + CNT_W'(1);

        frm_d = frm_wrap ? '0 : frm_q + FRM_W'(1);
        com_d = com_q ^ frm_wrap;

        // load wins over a coincident tick, so no pulse is produced for it
        step_d = tick && !load_i;
        wrap_d = step_d && carry[DIGITS];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            frm_q  <= '0;
            com_q  <= 1'b0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            frm_q  <= frm_d;
            com_q  <= com_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bb_bcd_digit_updn u_dig (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .tick_i     (tick),
            .up_i       (up_i),
            .load_i     (load_i),
            .load_dig_i (load_val_i[4*g +: 4]),
            .cin_i      (carry[g]),
            .dig_o      (cnt_o[4*g +: 4]),
            .cout_o     (carry[g+1])
        );
    end

    // Blank zeros from the MSD down until the first non-zero digit; digit 0 always shows.
    always_comb begin
        lead  = 1'b1;
        blank = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (cnt_o[4*d +: 4] == 4'd0)) blank[d] = blank_lz_i;
            else                                   lead     = 1'b0;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign lcdseg_o[7*g +: 7] = (blank[g] ? SEG_BLANK : seg7(cnt_o[4*g +: 4])) ^ {7{com_q}};
    end

    assign step_o   = step_q;
    assign wrap_o   = wrap_q;
    assign lcdcom_o = com_q;

endmodule

// File: tb/tb_bb_lcd_ncnt.sv
// Self-checking bench for bb_lcd_ncnt: directed literal checks plus randomized
// stimulus compared every cycle against a digit-array reference model.
module tb_bb_lcd_ncnt;

    localparam int D    = 3;
    localparam int CDIV = 4;
    localparam int FDIV = 2;
    localparam int CW   = 4 * D;
    localparam int SW   = 7 * D;

    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] PAT_E = 7'h39;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, up = 1'b1, load = 1'b0, blank_lz = 1'b1;
    logic [CW-1:0] load_val = '0;
    logic [CW-1:0] cnt;
    logic          step, wrap, lcdcom;
    logic [SW-1:0] lcdseg;

    int total = 0;
    int bad   = 0;

    int m_dig [D];
    int m_pre, m_n;
    bit m_step, m_wrap;

    bb_lcd_ncnt #(.DIGITS(D), .CNT_DIV(CDIV), .FRAME_DIV(FDIV)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .up_i       (up),
        .load_i     (load),
        .load_val_i (load_val),
        .blank_lz_i (blank_lz),
        .cnt_o      (cnt),
        .step_o     (step),
        .wrap_o     (wrap),
        .lcdcom_o   (lcdcom),
        .lcdseg_o   (lcdseg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_com();
        return bit'((m_n / FDIV) % 2);
    endfunction

    function automatic logic [CW-1:0] m_cnt();
        logic [CW-1:0] v = '0;
        for (int d = 0; d < D; d++) v[4*d +: 4] = 4'(m_dig[d]);
        return v;
    endfunction

    function automatic logic [SW-1:0] m_seg();
        logic [SW-1:0] v = '0;
        logic [6:0]    p;
        int            h = -1;
        for (int d = 0; d < D; d++) if (m_dig[d] != 0) h = d;
        for (int d = 0; d < D; d++) begin
            if (blank_lz && d > 0 && d > h) p = 7'h00;
            else if (m_dig[d] > 9)          p = PAT_E;
            else                            p = PAT[m_dig[d]];
            v[7*d +: 7] = p ^ {7{m_com()}};
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < D; d++) m_dig[d] = 0;
        m_pre  = 0;
        m_n    = 0;
        m_step = 0;
        m_wrap = 0;
    endtask

    task automatic model_clk();
        bit tick;
        bit c;
        tick = en && (m_pre == CDIV - 1);
        m_n++;
        if (load) begin
            for (int d = 0; d < D; d++) m_dig[d] = int'(load_val[4*d +: 4]);
            m_pre  = 0;
            m_step = 0;
            m_wrap = 0;
        end else begin
            if (en) m_pre = tick ? 0 : m_pre + 1;
            m_step = tick;
            m_wrap = 0;
            if (tick) begin
                c = 1;
                for (int d = 0; d < D; d++) begin
                    if (c) begin
                        if (up) begin
                            if (m_dig[d] >= 9) m_dig[d] = 0;
                            else begin m_dig[d]++; c = 0; end
                        end else begin
                            if (m_dig[d] == 0)     m_dig[d] = 9;
                            else if (m_dig[d] > 9) begin m_dig[d] = 9; c = 0; end
                            else begin m_dig[d]--; c = 0; end
                        end
                    end
                end
                m_wrap = c;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst) model_clk();
        #1;
        if (!rst) begin
            chk("cyc_cnt",    32'(cnt),    32'(m_cnt()));
            chk("cyc_step",   32'(step),   32'(m_step));
            chk("cyc_wrap",   32'(wrap),   32'(m_wrap));
            chk("cyc_lcdcom", 32'(lcdcom), 32'(m_com()));
            chk("cyc_lcdseg", 32'(lcdseg), 32'(m_seg()));
        end
    end

    task automatic load_bcd(input logic [CW-1:0] v);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        while (n < 3 * CDIV) begin
            @(posedge clk);
            #1;
            n++;
            if (step) break;
        end
        if (!step) chk("step_timeout", 32'(n), 32'(CDIV));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        #2;
        chk("rst_cnt",    32'(cnt),    32'h0);
        chk("rst_step",   32'(step),   32'h0);
        chk("rst_lcdcom", 32'(lcdcom), 32'h0);
        chk("rst_lcdseg", 32'(lcdseg), 32'h00003F);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // frame: lcdcom high after FDIV edges, segments inverted
        @(posedge clk); #1;
        chk("frm_com0", 32'(lcdcom), 32'h0);
        @(posedge clk); #1;
        chk("frm_com1", 32'(lcdcom), 32'h1);
        chk("frm_seg1", 32'(lcdseg), 32'h1FFFC0);

        @(negedge clk);
        en = 1'b1;
        up = 1'b1;
        wait_step(n);
        chk("first_step_lat", 32'(n),   32'd4);
        chk("first_step_cnt", 32'(cnt), 32'h001);

        load_bcd(12'h999);
        chk("ld999_cnt",  32'(cnt),  32'h999);
        chk("ld999_step", 32'(step), 32'h0);
        wait_step(n);
        chk("wrap_up_cnt",  32'(cnt),  32'h000);
        chk("wrap_up_wrap", 32'(wrap), 32'h1);
        chk("wrap_up_lat",  32'(n),    32'd4);

        @(negedge clk);
        up = 1'b0;
        load_bcd(12'h010);
        wait_step(n);
        chk("dn_09", 32'(cnt), 32'h009);
        wait_step(n);
        chk("dn_08", 32'(cnt), 32'h008);
        load_bcd(12'h000);
        wait_step(n);
        chk("wrap_dn_cnt",  32'(cnt),  32'h999);
        chk("wrap_dn_wrap", 32'(wrap), 32'h1);
        load_bcd(12'h00C);
        wait_step(n);
        chk("ill_dn_cnt",  32'(cnt),  32'h009);
        chk("ill_dn_wrap", 32'(wrap), 32'h0);

        // load coincident with a tick: loaded value, no step, next step 4 clk later
        repeat (4) @(negedge clk);
        load     = 1'b1;
        load_val = 12'h555;
        @(negedge clk);
        load = 1'b0;
        chk("ldtick_cnt",  32'(cnt),  32'h555);
        chk("ldtick_step", 32'(step), 32'h0);
        wait_step(n);
        chk("ldtick_next", 32'(n), 32'd4);

        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);

        blank_lz = 1'b1;
        load_bcd(12'h005);
        chk("blk_005", 32'(lcdseg), 32'({7'h00, 7'h00, 7'h6D} ^ {SW{m_com()}}));
        blank_lz = 1'b0;
        #1;
        chk("noblk_005", 32'(lcdseg), 32'({7'h3F, 7'h3F, 7'h6D} ^ {SW{m_com()}}));
        blank_lz = 1'b1;
        load_bcd(12'h050);
        chk("blk_050", 32'(lcdseg), 32'({7'h00, 7'h6D, 7'h3F} ^ {SW{m_com()}}));
        load_bcd(12'h000);
        chk("blk_000", 32'(lcdseg), 32'({7'h00, 7'h00, 7'h3F} ^ {SW{m_com()}}));
        load_bcd(12'h0A0);
        chk("blk_0A0", 32'(lcdseg), 32'({7'h00, 7'h39, 7'h3F} ^ {SW{m_com()}}));

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            en = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) up = ~up;
            if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
            load = ($urandom_range(11) == 0);
            case ($urandom_range(5))
                0:       load_val = 12'h999;
                1:       load_val = 12'h000;
                default: for (int d = 0; d < D; d++)
                             load_val[4*d +: 4] = ($urandom_range(9) == 0) ?
                                                  4'($urandom_range(15, 10)) :
                                                  4'($urandom_range(9));
            endcase
        end

        // asynchronous reset between edges while step is high
        @(negedge clk);
        en = 1'b1;
        up = 1'b1;
        load_bcd(12'h123);
        wait_step(n);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",    32'(cnt),    32'h0);
        chk("arst_step",   32'(step),   32'h0);
        chk("arst_lcdcom", 32'(lcdcom), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bb_lcd_ncnt.md
Name: bb_lcd_ncnt

Overview:
N-digit decimal up/down counter with a direct-drive (static, AC) 7-segment LCD driver. It is the parametrised successor of the two-digit demo counter. It is clocked by the 5 kHz OSCTIMER slow clock and derives the count step and the LCD frame rate internally with prescalers. It adds direction control, synchronous load, enable, leading-zero blanking and wrap/step status pulses.

Parameters:
DIGITS, 2, number of BCD digits / 7-segment groups (1..4)
CNT_DIV, 2048, clk cycles per count step (>=1)
FRAME_DIV, 32, clk cycles per half LCD frame, i.e. per lcdcom toggle (>=1)

Ports:
clk  in  1  slow clock (OSCTIMER TIMEROUT, 5 kHz)
rst  in  1  reset; one clock; reset is asynchronous and active-high
en  in  1  count enable; prescaler frozen while low
up  in  1  direction: 1 = increment, 0 = decrement
load  in  1  synchronous load of load_val, priority over counting
load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
blank_lz  in  1  1 = blank leading zero digits
cnt  out  4*DIGITS  current BCD count, digit 0 = least significant
step  out  1  one-cycle pulse, high in the cycle the new count is visible
wrap  out  1  one-cycle pulse, coincident with step, when the count wrapped
lcdcom  out  1  LCD common electrode, square wave
lcdseg  out  7*DIGITS  segment electrodes, digit d in bits [7d+6:7d], bit order a..g = 0..6

Behaviour:
- Reset (async): cnt=0, count prescaler=0, frame counter=0, lcdcom=0, step=0, wrap=0. Outputs stay at these values until the first clk edge after rst falls. Mid-operation reset has the same effect immediately.
- Count prescaler runs 0..CNT_DIV-1 while en=1 and holds its value while en=0. A tick occurs on the clk edge where prescaler==CNT_DIV-1 and en=1, and the prescaler returns to 0 on that edge. With CNT_DIV=1, a tick occurs every cycle while en=1.
- Tick with up=1: digit 0 increments. A digit >=9 becomes 0 and carries into the next digit. A ripple carry out of the MSD is a wrap: 99..9 -> 00..0.
- Tick with up=0: digit 0 decrements. A digit ==0 becomes 9 and borrows from the next digit. Borrow out of the MSD is a wrap: 00..0 -> 99..9. A digit >9 (illegal value, possible only via load) becomes 9 with no borrow.
- load=1: cnt<=load_val and prescaler<=0 regardless of en or tick. There is no step or wrap pulse. Illegal digits are loaded unchanged.
- step and wrap are registered. step=1 for exactly the one cycle following a counting tick, and is 0 after a load. wrap=1 only together with step.
- up changes take effect on the next tick. en low never affects the frame logic.
- Frame counter runs 0..FRAME_DIV-1 continuously and is independent of en and load. lcdcom toggles when the counter wraps, giving a period of 2*FRAME_DIV cycles and 50% duty.
- Segment decode per digit: 0..9 use the standard patterns (0=0111111, 1=0000110, ..., 8=1111111, 9=1101111). Any value >9 decodes to "E" (0111001).
- Leading-zero blanking (blank_lz=1): scanning from the MSD downward, each digit that is 0 and has only zero digits above it is blanked (pattern 0000000). Digit 0 is never blanked. blank_lz=0 shows all digits.
- lcdseg = pattern XOR replicated lcdcom. A blanked or off segment therefore equals lcdcom, so no DC is ever applied. lcdseg is combinational from registered cnt and lcdcom, with zero-cycle latency.

Decomposition:
- Package bb_lcd_pkg: SEG_BLANK, SEG_E and digit pattern constants; function seg7(bcd); functions bcd_inc and bcd_dec, each returning {carry, digit}.
- One sub-module, bb_bcd_digit_updn: 4-bit digit register with async rst, tick, up, load, load digit, carry/borrow in, and carry/borrow out. Instantiate it DIGITS times in a generate chain, with the top holding the prescalers, pulse registers and blanking/decode logic.

Test Plan:
- Reset/frame (DIGITS=2, FRAME_DIV=2): hold rst mid-run -> cnt=00, lcdcom=0, lcdseg={0000000 if blank_lz else 0111111, 0111111}. After release, lcdcom toggles every 2 clk, and lcdseg inverts bitwise on each toggle.
- Up count (CNT_DIV=4, en=1, up=1): first step after 4 clk. Load 98 then count -> 99, then 00 with wrap=1 and step=1 for one cycle; step period is 4 clk.
- Down count / borrow: load 10, up=0 -> 09, 08. Load 00 -> next tick gives 99 with wrap=1. Load digit 0 = 4'hC, up=0 -> digit becomes 9 with no borrow.
- Enable/load priority: en=0 for 10 clk -> cnt and prescaler frozen, lcdcom still toggling. load and tick asserted in the same cycle -> cnt=load_val, step=0, next step 4 clk later.
- Blanking (DIGITS=3, blank_lz=1): cnt 005 -> digits 2 and 1 blanked. cnt 050 -> only digit 2 blanked. cnt 000 -> digit 0 shows 0. Load 4'hA into digit 1 -> "E" pattern.
- Async reset mid-count: assert rst between clk edges -> cnt=0 and step=0 immediately, without waiting for a clk edge.
